clk_prescaler: RTL and testbench

- Programmable clock prescaler producing a registered, glitch-free divided clock `OUT_CLK` from `CLK`.
- High time and low time are set independently by two 4-bit inputs, so the block gives a programmable period and duty cycle.
- Sits between the system clock and slow peripherals (blinkers, scanners, baud-ish ticks).
- New settings take effect only at a period boundary, so no runt pulses are produced.

---
 rtl/clk_prescaler_if.sv | 8 +
 rtl/clk_prescaler.sv | 52 +++++
 tb/tb_clk_prescaler.sv | 130 +++++++++++++
 3 files changed

// File: rtl/clk_prescaler_if.sv
// clk_prescaler_if: phase-length codes in, divided clock out.
interface clk_prescaler_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] IN1;
  logic [WIDTH-1:0] IN2;
  logic             OUT_CLK;
  modport master(output IN1, output IN2, input OUT_CLK);
  modport slave(input IN1, input IN2, output OUT_CLK);
endinterface

// File: rtl/clk_prescaler.sv
// clk_prescaler: registered divided clock with independent high/low lengths, updated only at period boundaries.
module clk_prescaler #(parameter int WIDTH = 4) (
  input  logic           CLK,
  input  logic           RST,
  clk_prescaler_if.slave bus
);
  typedef enum logic [1:0] {START, HIGH, LOW} state_t;
  state_t           state;
  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] shadow_hi;
  logic [WIDTH-1:0] shadow_lo;
  logic             out_q;
  assign bus.OUT_CLK = out_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_q     <= 1'b0;
      counter   <= '0;
      shadow_hi <= '0;
      shadow_lo <= '0;
      state     <= START;
    end else begin
      case (state)
        START: begin
          shadow_hi <= bus.IN1;
          shadow_lo <= bus.IN2;
          out_q     <= 1'b1;
          counter   <= '0;
          state     <= HIGH;
        end
        HIGH:
          if (counter == shadow_hi) begin
            out_q   <= 1'b0;
            counter <= '0;
            state   <= LOW;
          end else counter <= counter + 1'b1;
        LOW:
          if (counter == shadow_lo) begin
            shadow_hi <= bus.IN1;
            shadow_lo <= bus.IN2;
            out_q     <= 1'b1;
            counter   <= '0;
            state     <= HIGH;
          end else counter <= counter + 1'b1;
        default: begin
          out_q   <= 1'b0;
          counter <= '0;
          state   <= START;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_clk_prescaler.sv
// tb_clk_prescaler: directed waveform checks of the prescaler, sampled on falling CLK edges.
module tb_clk_prescaler;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int checks = 0;
  int errors = 0;
  clk_prescaler_if #(.WIDTH(4)) bus();
  clk_prescaler #(.WIDTH(4)) dut(.CLK(CLK), .RST(RST), .bus(bus));
  always #20 CLK = ~CLK;
  // k counts falling edges after the first high-going edge; hi/lo are cycle counts
  function automatic logic exp_bit(input int k, input int hi, input int lo);
    return (k % (hi + lo)) < hi;
  endfunction
  task automatic do_reset(input logic [3:0] in1, input logic [3:0] in2);
    @(negedge CLK);
    RST = 1'b1;
    bus.IN1 = in1;
    bus.IN2 = in2;
    @(negedge CLK);
    RST = 1'b0;
  endtask
  task automatic test_reset;
    bus.IN1 = 4'd0;
    bus.IN2 = 4'd0;
    RST = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      checks++;
      if (bus.OUT_CLK !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %b want 0", k, bus.OUT_CLK);
      end
    end
    RST = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      checks++;
      if (bus.OUT_CLK !== exp_bit(k, 1, 1)) begin
        errors++;
        $display("FAIL div2 cycle %0d: got %b want %b", k, bus.OUT_CLK, exp_bit(k, 1, 1));
      end
    end
  endtask
  task automatic test_duty_3_1;
    do_reset(4'd3, 4'd1);
    for (int k = 0; k < 18; k++) begin
      @(negedge CLK);
      checks++;
      if (bus.OUT_CLK !== exp_bit(k, 4, 2)) begin
        errors++;
        $display("FAIL duty_3_1 cycle %0d: got %b want %b", k, bus.OUT_CLK, exp_bit(k, 4, 2));
      end
    end
  endtask
  task automatic test_max;
    do_reset(4'd15, 4'd15);
    for (int k = 0; k < 70; k++) begin
      @(negedge CLK);
      checks++;
      if (bus.OUT_CLK !== exp_bit(k, 16, 16)) begin
        errors++;
        $display("FAIL max_period cycle %0d: got %b want %b", k, bus.OUT_CLK, exp_bit(k, 16, 16));
      end
    end
  endtask
  task automatic test_change_mid_period;
    logic e;
    do_reset(4'd2, 4'd2);
    for (int k = 0; k < 24; k++) begin
      @(negedge CLK);
      e = (k < 6) ? exp_bit(k, 3, 3) : exp_bit(k - 6, 1, 6);
      checks++;
      if (bus.OUT_CLK !== e) begin
        errors++;
        $display("FAIL change_mid cycle %0d: got %b want %b", k, bus.OUT_CLK, e);
      end
      if (k == 1) begin
        bus.IN1 = 4'd0;
        bus.IN2 = 4'd5;
      end
    end
  endtask
  task automatic test_async_reset;
    do_reset(4'd2, 4'd4);
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (bus.OUT_CLK !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: got %b want 1", bus.OUT_CLK);
    end
    #5 RST = 1'b1;
    #1;
    checks++;
    if (bus.OUT_CLK !== 1'b0) begin
      errors++;
      $display("FAIL async_drop: got %b want 0", bus.OUT_CLK);
    end
    RST = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK);
      checks++;
      if (bus.OUT_CLK !== exp_bit(k, 3, 5)) begin
        errors++;
        $display("FAIL async_restart cycle %0d: got %b want %b", k, bus.OUT_CLK, exp_bit(k, 3, 5));
      end
    end
  endtask
  task automatic test_pulse;
    do_reset(4'd0, 4'd7);
    for (int k = 0; k < 27; k++) begin
      @(negedge CLK);
      checks++;
      if (bus.OUT_CLK !== exp_bit(k, 1, 8)) begin
        errors++;
        $display("FAIL pulse_0_7 cycle %0d: got %b want %b", k, bus.OUT_CLK, exp_bit(k, 1, 8));
      end
    end
  endtask
  initial begin
    test_reset();
    test_duty_3_1();
    test_max();
    test_change_mid_period();
    test_async_reset();
    test_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
